// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit -- multi-cycle multiply/divide unit for the EX stage.
//
// Owns the HI/LO registers. mult/multu/div/divu are latched on acceptance and
// write HI/LO after a fixed latency of MULT_CYCLES / DIV_CYCLES clocks.
// mthi/mtlo write HI/LO from rs at the next edge. mfhi/mflo read HI/LO
// combinationally on rdata. Any MDU op presented while a mult/div is in
// flight raises stall and is ignored until busy drops.
//
// Optional feature (compile-time macro MDU_CANCEL_EN):
//   defined   -> flush port exists; flush aborts an in-flight op without
//                touching HI/LO and blocks acceptance of any op in IDLE.
//   undefined -> no flush port; an accepted op always completes.
//
// Parameters:
//   MULT_CYCLES  latency of mult/multu, 1..63
//   DIV_CYCLES   latency of div/divu,  1..63
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mduEnable  EX instruction is an MDU op
//   mduStart   op is mult/multu/div/divu
//   mduOp      0 mfhi, 1 mflo, 2 mthi, 3 mtlo, 4 mult, 5 multu, 6 div, 7 divu
//   rs, rt     forwarded operands
//   flush      cancel in-flight op (MDU_CANCEL_EN only)
//   rdata      HI for mduOp 0, LO for mduOp 1, else 0 (combinational)
//   busy       1 while a mult/div is in flight (register output)
//   stall      mduEnable & busy (combinational)
// ---------------------------------------------------------------------------
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mduEnable,
    input  logic        mduStart,
    input  logic [2:0]  mduOp,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
`ifdef MDU_CANCEL_EN
    input  logic        flush,
`endif
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

    state_t      state, state_next;
    logic [5:0]  count, count_next;
    logic [31:0] hi, lo;
    logic [31:0] op_a, op_b;
    logic [1:0]  op_kind;        // mduOp[1:0] of the latched op: 0 mult, 1 multu, 2 div, 3 divu

    logic        flush_int;
    logic        accept_start;
    logic        write_hi_rs;
    logic        write_lo_rs;
    logic        complete;

`ifdef MDU_CANCEL_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_next   = state;
        count_next   = count;
        accept_start = 1'b0;
        write_hi_rs  = 1'b0;
        write_lo_rs  = 1'b0;
        complete     = 1'b0;

        case (state)
            IDLE: begin
                if (mduEnable && !flush_int) begin
                    if (mduOp[2]) begin
                        if (mduStart) begin
                            accept_start = 1'b1;
                            state_next   = BUSY;
                            count_next   = mduOp[1] ? DIV_LOAD : MULT_LOAD;
                        end
                    end else if (mduOp == 3'd2) begin
                        write_hi_rs = 1'b1;
                    end else if (mduOp == 3'd3) begin
                        write_lo_rs = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Flush outranks completion in the final cycle.
                if (flush_int) begin
                    state_next = IDLE;
                    count_next = 6'd0;
                end else if (count == 6'd1) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                    count_next = 6'd0;
                end else begin
                    count_next = count - 6'd1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 6'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    logic        is_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] q_mag, r_mag;
    logic [63:0] product;
    logic [31:0] quot, rem;
    logic        div_zero;
    logic [31:0] res_hi, res_lo;

    assign is_signed = ~op_kind[0];
    assign div_zero  = (op_b == 32'd0);

    always_comb begin
        product = 64'd0;
        if (is_signed) begin
            product = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        end else begin
            product = {32'd0, op_a} * {32'd0, op_b};
        end
    end

    // Signed division is done on magnitudes so that 0x80000000 / -1 is well
    // defined: |0x80000000| stays 0x80000000 unsigned, and the quotient sign
    // is positive, giving LO=0x80000000, HI=0.
    always_comb begin
        a_neg = is_signed & op_a[31];
        b_neg = is_signed & op_b[31];
        a_mag = a_neg ? (32'd0 - op_a) : op_a;
        b_mag = b_neg ? (32'd0 - op_b) : op_b;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;   // remainder follows the dividend
    end

    always_comb begin
        res_hi = product[63:32];
        res_lo = product[31:0];
        if (op_kind[1]) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    // ------------------------------------------------------------------
    // State, operands, HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 6'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_kind <= 2'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the pre-edge values, independent of statement order.
            state <= state_next;
            count <= count_next;
            if (accept_start) begin
                op_a    <= rs;
                op_b    <= rt;
                op_kind <= mduOp[1:0];
            end
            if (write_hi_rs) begin
                hi <= rs;
            end
            if (write_lo_rs) begin
                lo <= rs;
            end
            // A divide by zero runs the full latency but leaves HI/LO alone.
            if (complete && !(op_kind[1] && div_zero)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy  = (state == BUSY);
    assign stall = mduEnable & busy;

    always_comb begin
        rdata = 32'd0;
        if (mduOp == 3'd0) begin
            rdata = hi;
        end else if (mduOp == 3'd1) begin
            rdata = lo;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// ---------------------------------------------------------------------------
// tb_mdu_unit -- self-checking bench for mdu_unit.
// Directed steps from the test plan, then randomized mult/div operations
// checked against a plain-arithmetic reference of HI/LO.
// ---------------------------------------------------------------------------
module tb_mdu_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        rst;
    logic        mdu_enable;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic [31:0] rs_in;
    logic [31:0] rt_in;
    logic        flush;
    logic [31:0] rdata;
    logic        busy;
    logic        stall;

    int errors = 0;
    int checks = 0;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mduEnable (mdu_enable),
        .mduStart  (mdu_start),
        .mduOp     (mdu_op),
        .rs        (rs_in),
        .rt        (rt_in),
`ifdef MDU_CANCEL_EN
        .flush     (flush),
`endif
        .rdata     (rdata),
        .busy      (busy),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: architectural result of an MDU op on HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, up;
        case (op)
            3'd4: begin
                sa = $signed(a);
                sb = $signed(b);
                up = 64'(sa * sb);
                hi = up[63:32];
                lo = up[31:0];
            end
            3'd5: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
            end
            3'd6: begin
                if (b != 32'd0) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
            3'd7: begin
                if (b != 32'd0) begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Read HI and LO through mfhi/mflo in the current (idle) cycle.
    task automatic read_expect(input string tag, input logic [31:0] hexp, input logic [31:0] lexp);
        mdu_enable = 1'b1;
        mdu_start  = 1'b0;
        mdu_op     = 3'd0;
        #1;
        check({tag, "_hi"}, rdata, hexp);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        mdu_op = 3'd1;
        #1;
        check({tag, "_lo"}, rdata, lexp);
        mdu_enable = 1'b0;
        mdu_op     = 3'd0;
    endtask

    task automatic move(input logic [2:0] op, input logic [31:0] v);
        mdu_enable = 1'b1;
        mdu_start  = 1'b0;
        mdu_op     = op;
        rs_in      = v;
        tick();
        mdu_enable = 1'b0;
        mdu_op     = 3'd0;
        if (op == 3'd2) hi_m = v;
        if (op == 3'd3) lo_m = v;
    endtask

    // Issue a mult/div, scramble rs/rt after acceptance, check the busy window.
    // With hold set an mflo is held in EX for the whole window.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        int n;
        n = op[1] ? DIV_N : MULT_N;
        mdu_enable = 1'b1;
        mdu_start  = 1'b1;
        mdu_op     = op;
        rs_in      = a;
        rt_in      = b;
        #1;
        check({tag, "_stall_idle"}, {31'd0, stall}, 32'd0);
        tick();
        rs_in      = $urandom;
        rt_in      = $urandom;
        mdu_start  = 1'b0;
        mdu_enable = hold;
        mdu_op     = hold ? 3'd1 : 3'd0;
        #1;
        for (int k = 0; k < n; k++) begin
            check({tag, "_busy_window"}, {31'd0, busy}, 32'd1);
            check({tag, "_stall_window"}, {31'd0, stall}, {31'd0, hold});
            tick();
        end
        model(op, a, b, hi_m, lo_m);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        if (hold) check({tag, "_held_mflo"}, rdata, lo_m);
        mdu_enable = 1'b0;
        mdu_op     = 3'd0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst        = 1'b1;
        mdu_enable = 1'b0;
        mdu_start  = 1'b0;
        mdu_op     = 3'd0;
        rs_in      = 32'd0;
        rt_in      = 32'd0;
        flush      = 1'b0;
        hi_m       = 32'd0;
        lo_m       = 32'd0;

        // Reset state
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", rdata, 32'd0);
        mdu_op = 3'd1;
        #1;
        check("reset_lo", rdata, 32'd0);
        mdu_op = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // mduStart without mduEnable is ignored
        mdu_start = 1'b1;
        mdu_op    = 3'd4;
        rs_in     = 32'd3;
        rt_in     = 32'd3;
        tick();
        check("start_no_enable", {31'd0, busy}, 32'd0);
        mdu_start = 1'b0;
        mdu_op    = 3'd0;

        // Test-plan directed cases with fixed expected values
        run_op("mult_neg", 3'd4, 32'hFFFF_FFF9, 32'd3, 1'b0);
        read_expect("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        run_op("multu_max", 3'd5, 32'hFFFF_FFFF, 32'd2, 1'b0);
        read_expect("multu_max", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op("div_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        read_expect("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        move(3'd2, 32'h11);
        move(3'd3, 32'h22);
        read_expect("mthi_mtlo", 32'h11, 32'h22);
        run_op("divu_zero", 3'd7, 32'd7, 32'd0, 1'b0);
        read_expect("divu_zero", 32'h11, 32'h22);

        run_op("div_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        read_expect("div_ovf", 32'h0000_0000, 32'h8000_0000);

        // Stall: mflo held behind a div is served with the new LO
        run_op("div_stall", 3'd6, 32'd100, 32'd7, 1'b1);
        read_expect("div_stall", 32'd2, 32'd14);

        // Randomized ops against the reference
        for (int i = 0; i < 16; i++) begin
            rop = 3'(4 + $urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            run_op("rand", rop, ra, rb, ($urandom_range(0, 1) == 1));
            read_expect("rand", hi_m, lo_m);
        end

        // Reset three cycles into a mult
        move(3'd2, 32'h5);
        move(3'd3, 32'h6);
        mdu_enable = 1'b1;
        mdu_start  = 1'b1;
        mdu_op     = 3'd4;
        rs_in      = 32'd9;
        rt_in      = 32'd9;
        tick();
        mdu_enable = 1'b0;
        mdu_start  = 1'b0;
        mdu_op     = 3'd0;
        tick();
        tick();
        tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_hi", rdata, 32'd0);
        mdu_op = 3'd1;
        #1;
        check("mid_reset_lo", rdata, 32'd0);
        mdu_op = 3'd0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < MULT_N + 2; k++) tick();
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        read_expect("post_reset", 32'd0, 32'd0);

`ifdef MDU_CANCEL_EN
        // Flush at cycle 2 of a div leaves HI/LO unchanged
        move(3'd2, 32'hAA);
        move(3'd3, 32'hBB);
        mdu_enable = 1'b1;
        mdu_start  = 1'b1;
        mdu_op     = 3'd6;
        rs_in      = 32'd50;
        rt_in      = 32'd5;
        tick();
        mdu_enable = 1'b0;
        mdu_start  = 1'b0;
        mdu_op     = 3'd0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < DIV_N; k++) tick();
        read_expect("flush_div", 32'hAA, 32'hBB);

        // Flush in IDLE blocks mthi
        mdu_enable = 1'b1;
        mdu_op     = 3'd2;
        rs_in      = 32'hDEAD;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        mdu_enable = 1'b0;
        read_expect("flush_idle", 32'hAA, 32'hBB);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
